// File: rtl/nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_addsub
// Purpose  : Wide add/subtract built from one 4-bit adder slice, one nibble/clk.
// Revision : 1.0
// ============================================================================
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iStart,
    input  logic                   iSub,
    input  logic [4*NIBBLES-1:0]   iA,
    input  logic [4*NIBBLES-1:0]   iB,
    output logic                   oBusy,
    output logic                   oDone,
    output logic [4*NIBBLES-1:0]   oResult,
    output logic                   oCarry,
    output logic                   oOverflow
);

    localparam int c_W  = 4 * NIBBLES;
    localparam int c_KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_KW-1:0] c_LAST = c_KW'(NIBBLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_W-1:0]  r_opA;
    logic [c_W-1:0]  r_opB;
    logic [c_W-1:0]  r_sum;
    logic            r_carry;
    logic [c_KW-1:0] r_nibCnt;

    logic [4:0]      w_nibSum;
    logic [3:0]      w_low3Sum;
    logic            w_carryIntoMsb;
    logic            w_lastNib;
    logic [c_W-1:0]  w_opANext;
    logic [c_W-1:0]  w_opBNext;
    logic [c_W-1:0]  w_sumNext;

    // The single shared slice; the 3-bit partial sum exposes the carry into bit 3.
    assign w_nibSum       = {1'b0, r_opA[3:0]} + {1'b0, r_opB[3:0]} + {4'b0, r_carry};
    assign w_low3Sum      = {1'b0, r_opA[2:0]} + {1'b0, r_opB[2:0]} + {3'b0, r_carry};
    assign w_carryIntoMsb = w_low3Sum[3];
    assign w_lastNib      = (r_nibCnt == c_LAST);

    generate
        if (NIBBLES == 1) begin : g_singleNibble
            assign w_opANext = '0;
            assign w_opBNext = '0;
            assign w_sumNext = w_nibSum[3:0];
        end else begin : g_multiNibble
            assign w_opANext = {4'b0, r_opA[c_W-1:4]};
            assign w_opBNext = {4'b0, r_opB[c_W-1:4]};
            assign w_sumNext = {w_nibSum[3:0], r_sum[c_W-1:4]};
        end
    endgenerate

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state   <= IDLE;
            r_opA     <= '0;
            r_opB     <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_nibCnt  <= '0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oResult   <= '0;
            oCarry    <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (iStart) begin
                        // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
                        r_opA    <= iA;
                        r_opB    <= iSub ? ~iB : iB;
                        r_carry  <= iSub;
                        r_nibCnt <= '0;
                        oBusy    <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_opA    <= w_opANext;
                    r_opB    <= w_opBNext;
                    r_sum    <= w_sumNext;
                    r_carry  <= w_nibSum[4];
                    r_nibCnt <= r_nibCnt + 1'b1;
                    if (w_lastNib) begin
                        oResult   <= w_sumNext;
                        oCarry    <= w_nibSum[4];
                        oOverflow <= w_carryIntoMsb ^ w_nibSum[4];
                        oDone     <= 1'b1;
                        oBusy     <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    oBusy   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_addsub
// Purpose  : Directed self-checking bench for nibble_serial_addsub (NIBBLES=4).
// Revision : 1.0
// ============================================================================
module tb_nibble_serial_addsub;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iStart;
    logic        iSub;
    logic [15:0] iA;
    logic [15:0] iB;
    logic        oBusy;
    logic        oDone;
    logic [15:0] oResult;
    logic        oCarry;
    logic        oOverflow;

    int checkCnt = 0;
    int failCnt  = 0;

    nibble_serial_addsub #(.NIBBLES(4)) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iStart    (iStart),
        .iSub      (iSub),
        .iA        (iA),
        .iB        (iB),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oResult   (oResult),
        .oCarry    (oCarry),
        .oOverflow (oOverflow)
    );

    always #5 iClk = ~iClk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts one operation, scrambles the inputs after the start edge, and
    // returns at the negedge of the oDone cycle (or after a bounded wait).
    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] expR, input logic expC,
                         input logic expV);
        int busyCyc;
        logic seen;
        busyCyc = 0;
        seen    = 1'b0;
        @(negedge iClk);
        iA = a; iB = b; iSub = s; iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        iA     = 16'($urandom);
        iB     = 16'($urandom);
        iSub   = ~s;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge iClk);
            if (oDone) seen = 1'b1;
            else if (oBusy) busyCyc++;
        end
        checkValue({tag, "_done"}, {31'b0, seen}, 32'd1);
        checkValue({tag, "_busyCycles"}, busyCyc, 32'd4);
        checkValue({tag, "_busyInDone"}, {31'b0, oBusy}, 32'd0);
        checkValue({tag, "_result"}, {16'b0, oResult}, {16'b0, expR});
        checkValue({tag, "_carry"}, {31'b0, oCarry}, {31'b0, expC});
        checkValue({tag, "_overflow"}, {31'b0, oOverflow}, {31'b0, expV});
    endtask

    initial begin
        int doneCnt;
        logic seen;
        iRst_n = 1'b0; iStart = 1'b0; iSub = 1'b0; iA = '0; iB = '0;
        repeat (2) @(negedge iClk);
        checkValue("reset_busy",   {31'b0, oBusy},   32'd0);
        checkValue("reset_done",   {31'b0, oDone},   32'd0);
        checkValue("reset_result", {16'b0, oResult}, 32'd0);
        iRst_n = 1'b1;

        runOp("add",       16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        runOp("addWrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp("addOvf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        runOp("subNeg",    16'h0005, 16'h000A, 1'b1, 16'hFFFB, 1'b0, 1'b0);
        runOp("subOvf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        runOp("subEqual",  16'h000A, 16'h000A, 1'b1, 16'h0000, 1'b1, 1'b0);
        runOp("subOvfAgn", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Reset in the middle of an operation
        @(negedge iClk);
        iA = 16'h1234; iB = 16'h0FFF; iSub = 1'b0; iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
        repeat (2) @(posedge iClk);
        #1 iRst_n = 1'b0;
        #1;
        checkValue("midRst_busy",     {31'b0, oBusy},     32'd0);
        checkValue("midRst_result",   {16'b0, oResult},   32'd0);
        checkValue("midRst_carry",    {31'b0, oCarry},    32'd0);
        checkValue("midRst_overflow", {31'b0, oOverflow}, 32'd0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge iClk);
            if (oDone) doneCnt++;
        end
        checkValue("midRst_noDone", doneCnt, 32'd0);
        runOp("postRst", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);

        // iStart held through RUN while iA changes: one completion, original operands
        runOp("prep", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        @(negedge iClk);
        iA = 16'h1234; iB = 16'h0FFF; iSub = 1'b0; iStart = 1'b1;
        @(posedge iClk);
        #1 iA = 16'hAAAA;
        repeat (3) @(posedge iClk);
        #1 iStart = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk);
            if (oDone) begin
                doneCnt++;
                checkValue("held_result", {16'b0, oResult}, 32'h2233);
            end
        end
        checkValue("held_doneCount", doneCnt, 32'd1);

        // Back-to-back start issued in the oDone cycle
        runOp("b2bFirst", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        iA = 16'h0003; iB = 16'h0004; iSub = 1'b0; iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            if (oDone) seen = 1'b1;
            checkValue("b2b_heldResult", {16'b0, oResult}, 32'h0000);
            checkValue("b2b_heldCarry",  {31'b0, oCarry},  32'd1);
        end
        checkValue("b2b_earlyDone", {31'b0, seen}, 32'd0);
        @(negedge iClk);
        checkValue("b2b_done",   {31'b0, oDone},   32'd1);
        checkValue("b2b_result", {16'b0, oResult}, 32'h0007);
        checkValue("b2b_carry",  {31'b0, oCarry},  32'd0);
        @(negedge iClk);
        checkValue("b2b_singlePulse", {31'b0, oDone}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle add/subtract unit that reuses one 4-bit adder slice, with carry chaining, to compute wide sums and differences one nibble per clock. It serves the motion-control datapath for position-error and setpoint arithmetic (target − encoder count, accumulate step deltas) where LE budget matters more than latency. A single-cycle start/done handshake connects it to the motion sequencer.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..8.
- iClk  in  1  system clock; all registers update on its rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iStart  in  1  start request; sampled only in IDLE.
- iSub  in  1  0 = A+B, 1 = A−B; latched with the operands.
- iA  in  W  operand A, latched on the accepted start edge.
- iB  in  W  operand B, latched on the accepted start edge.
- oBusy  out  1  high while an operation is in progress.
- oDone  out  1  one-cycle pulse when oResult/oCarry/oOverflow are updated.
- oResult  out  W  result, modulo 2^W.
- oCarry  out  1  add: unsigned carry-out; sub: 1 = no borrow (A ≥ B unsigned).
- oOverflow  out  1  two's-complement signed overflow of the operation.

## Operation
- FSM states: IDLE, RUN.
- IDLE → RUN on a rising edge with iStart=1. On that edge:
  - latch iA into shift register SA;
  - latch iB, or ~iB when iSub=1, into SB;
  - set carry register C = iSub;
  - clear nibble counter K to 0.
- RUN, every edge:
  - {c4, s} = SA[3:0] + SB[3:0] + C;
  - shift s into the top of the result shift register SR;
  - shift SA and SB right by 4;
  - C ← c4; K ← K+1.
- On the edge processing nibble K = NIBBLES−1:
  - oResult ← final SR contents;
  - oCarry ← c4;
  - oOverflow ← carry-into-MSB XOR c4 (carry-into-MSB taken from that nibble's bit-3 internal carry);
  - oDone ← 1; FSM → IDLE.
- oResult, oCarry and oOverflow hold their values until the next completion; they never show partial results.
- iStart in RUN is ignored and not queued. iA, iB and iSub may change freely after the start edge.

## Timing
- Reset (async assert, any state): FSM = IDLE; K, SA, SB, SR, C = 0; oBusy = 0, oDone = 0, oResult = 0, oCarry = 0, oOverflow = 0. An operation in flight is discarded.
- Reset release is synchronous to iClk; the first start can be accepted on the first edge after deassertion.
- Start accepted on edge E0. oBusy = 1 from after E0 through edge E0+NIBBLES.
- Results update on edge E0+NIBBLES. oDone is high for exactly the cycle following that edge, and oBusy is low in that same cycle.
- Latency is NIBBLES cycles from start edge to results. NIBBLES = 1 gives a one-cycle latency.
- Back-to-back operation: iStart=1 during the oDone cycle is accepted (FSM is IDLE). Sustained throughput is one operation per NIBBLES+1 cycles.
- oDone is never asserted twice for one start, and never asserted without a preceding accepted start.

## Test plan
All cases use NIBBLES=4 (W=16).
- Reset: assert iRst_n=0 mid-RUN, 2 cycles after start with iA=0x1234, iB=0x0FFF → all outputs 0 immediately, no oDone follows; after release, start the same add → oResult=0x2233.
- Add timing: iStart at edge E0, iA=0x1234, iB=0x0FFF, iSub=0 → oBusy high for 4 cycles; oDone pulse after E0+4; oResult=0x2233, oCarry=0, oOverflow=0.
- Add wrap and overflow:
  - 0xFFFF+0x0001 → 0x0000, oCarry=1, oOverflow=0;
  - 0x7FFF+0x0001 → 0x8000, oCarry=0, oOverflow=1.
- Subtract:
  - 0x0005−0x000A → 0xFFFB, oCarry=0, oOverflow=0;
  - 0x8000−0x0001 → 0x7FFF, oCarry=1, oOverflow=1;
  - 0x000A−0x000A → 0x0000, oCarry=1.
- Handshake:
  - iStart held high and iA changed during RUN → exactly one oDone, with the result of the originally latched operands;
  - a second start in the oDone cycle (0x0003+0x0004) → 0x0007 four cycles later, with the previous result held in the meantime.
